// File: rtl/fifo_bit_serializer_pkg.sv
// Shared types and defaults for the BPSK transmit serializer.
package bpsk_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int UNIT_SIZE_DEF = 8;

endpackage

// File: rtl/fifo_bit_serializer_if.sv
// Show-ahead FIFO read port: the serializer side pops, the FIFO side presents head data.
interface fifo_bit_serializer_if #(
    parameter int UNIT_SIZE = 8
);
    logic                 fifo_valid;
    logic [UNIT_SIZE-1:0] fifo_data;
    logic                 fifo_pop;

    modport master (
        input  fifo_valid,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_valid,
        output fifo_data,
        input  fifo_pop
    );
endinterface

// File: rtl/fifo_bit_serializer_symbol_timer.sv
// Clocks-per-bit divider: counts 0..SYMBOL_DIV-1 while running, ticks on the wrap clock.
module fifo_bit_serializer_symbol_timer #(
    parameter int SYMBOL_DIV = 4,
    parameter int DIV_W      = $clog2(SYMBOL_DIV) + 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    input  logic clear,
    output logic tick
);
    logic [DIV_W-1:0] div_cnt_reg;

    assign tick = run && (div_cnt_reg == DIV_W'(SYMBOL_DIV - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt_reg <= '0;
        end else if (clear) begin
            div_cnt_reg <= '0;
        end else if (run) begin
            if (tick) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/fifo_bit_serializer.sv
// Pops words from a show-ahead FIFO and emits them as a bit stream with
// symbol strobe and BPSK phase select; consecutive words run back to back.
module fifo_bit_serializer
    import bpsk_pkg::*;
#(
    parameter int UNIT_SIZE  = UNIT_SIZE_DEF,
    parameter int SYMBOL_DIV = 4,
    parameter int MSB_FIRST  = 1,
    parameter int DIFF_ENC   = 0
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   en,
    fifo_bit_serializer_if.master  fifo_bus,
    output logic                   bit_out,
    output logic                   bit_strobe,
    output logic                   phase,
    output logic                   byte_done,
    output logic                   tx_active
);
    localparam int BIT_W = $clog2(UNIT_SIZE) + 1;

    ser_state_t           state_reg;
    logic [UNIT_SIZE-1:0] shreg_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic                 bit_out_reg;
    logic                 strobe_reg;
    logic                 phase_reg;

    logic                 tick;
    logic                 in_shift;
    logic                 last_clk;
    logic                 load_req;
    logic                 pop;
    logic [UNIT_SIZE-1:0] shreg_next;
    logic                 load_bit;
    logic                 shift_bit;

    assign in_shift = (state_reg == SHIFT);
    assign last_clk = tick && (bit_cnt_reg == BIT_W'(UNIT_SIZE - 1));
    assign load_req = ((state_reg == IDLE) && en) || last_clk;
    // Gated by n_rst so the FIFO never advances while the serializer is held in reset.
    assign pop      = load_req && fifo_bus.fifo_valid && en && n_rst;

    assign fifo_bus.fifo_pop = pop;
    assign bit_out    = bit_out_reg;
    assign bit_strobe = strobe_reg;
    assign phase      = phase_reg;
    assign byte_done  = last_clk;
    assign tx_active  = in_shift;

    always_comb begin
        shreg_next = shreg_reg;
        load_bit   = 1'b0;
        shift_bit  = 1'b0;
        if (MSB_FIRST != 0) begin
            shreg_next = shreg_reg << 1;
            load_bit   = fifo_bus.fifo_data[UNIT_SIZE-1];
            shift_bit  = shreg_next[UNIT_SIZE-1];
        end else begin
            shreg_next = shreg_reg >> 1;
            load_bit   = fifo_bus.fifo_data[0];
            shift_bit  = shreg_next[0];
        end
    end

    fifo_bit_serializer_symbol_timer #(
        .SYMBOL_DIV (SYMBOL_DIV)
    ) u_symbol_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .run   (in_shift),
        .clear (pop),
        .tick  (tick)
    );

    // The head of shreg_reg is always the bit currently on bit_out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            bit_out_reg <= 1'b0;
            strobe_reg  <= 1'b0;
            phase_reg   <= 1'b0;
        end else if (pop) begin
            state_reg   <= SHIFT;
            shreg_reg   <= fifo_bus.fifo_data;
            bit_cnt_reg <= '0;
            bit_out_reg <= load_bit;
            strobe_reg  <= 1'b1;
            phase_reg   <= (DIFF_ENC != 0) ? (phase_reg ^ load_bit) : load_bit;
        end else if (last_clk) begin
            // Nothing to send next: drop the line; phase keeps its last value.
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_out_reg <= 1'b0;
            strobe_reg  <= 1'b0;
        end else if (in_shift && tick) begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            bit_out_reg <= shift_bit;
            strobe_reg  <= 1'b1;
            phase_reg   <= (DIFF_ENC != 0) ? (phase_reg ^ shift_bit) : shift_bit;
        end else begin
            strobe_reg  <= 1'b0;
        end
    end
endmodule
